// File: rtl/ras_pkg.sv
// ras_pkg -- shared widths and FSM state type for the RAS halfword-to-word
// receiver (ras_rx32) and its 2-entry output FIFO (ras_fifo2).
//   HALF_W      : width of one incoming stream halfword
//   WORD_W      : width of one assembled output word
//   CNT_W       : width of the per-frame word counter and the frame counter
//   ras_state_t : receiver FSM states
package ras_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    DRAIN = 2'd3
  } ras_state_t;

endpackage

// File: rtl/ras_rx32_if.sv
// ras_rx32_if -- stream bundle for ras_rx32.
//   rasin_valid/rasin_data/rasin_ready : halfword stream into the receiver
//   out_valid/out_data/out_ready       : assembled word stream to the loader
// Modports:
//   slave  : the receiver (consumes halfwords, produces words)
//   master : the surrounding system (produces halfwords, consumes words)
interface ras_rx32_if;
  import ras_pkg::*;

  logic              rasin_valid;
  logic [HALF_W-1:0] rasin_data;
  logic              rasin_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  rasin_valid, rasin_data, out_ready,
    output rasin_ready, out_valid, out_data
  );

  modport master (
    output rasin_valid, rasin_data, out_ready,
    input  rasin_ready, out_valid, out_data
  );

endinterface

// File: rtl/ras_fifo2.sv
// ras_fifo2 -- 2-entry FIFO with registered occupancy.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or when full and
//                popping in the same cycle)
//   push_data  : data to write
//   pop        : discard the head entry (ignored when empty)
//   head       : current head entry (cleared by reset)
//   full/empty : occupancy flags
//   count      : registered occupancy, 0..2
module ras_fifo2
  import ras_pkg::*;
#(
  parameter int unsigned W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/ras_rx32.sv
// ras_rx32 -- RAS halfword stream to 32-bit word receiver.
// After ap_start in IDLE, collects WORDS pairs of halfwords (first halfword
// becomes bits [15:0], second bits [31:16]), queues each word in a 2-entry
// FIFO and, once the FIFO has drained, pulses done and returns to IDLE.
// Parameters:
//   WORDS : 32-bit words per frame, 1..65535
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   ap_start   : frame start request (only honoured in IDLE)
//   bus        : ras_rx32_if.slave (halfword stream in, word stream out)
//   done       : one-cycle pulse at frame completion
//   busy       : high whenever the FSM is not IDLE
//   frame_cnt  : completed-frame counter, only with RAS_RX32_FRAMECNT_EN
// Build option:
//   RAS_RX32_FRAMECNT_EN : adds the frame_cnt output and its register
module ras_rx32
  import ras_pkg::*;
#(
  parameter int unsigned WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ap_start,
  ras_rx32_if.slave        bus,
  output logic             done,
  output logic             busy
`ifdef RAS_RX32_FRAMECNT_EN
  ,
  output logic [CNT_W-1:0] frame_cnt
`endif
);

  ras_state_t        state;
  ras_state_t        state_nx;
  logic [HALF_W-1:0] hold;
  logic [CNT_W-1:0]  word_cnt;
  logic              rdy;
  logic              hs;
  logic              lo_hs;
  logic              push;
  logic              last_word;
  logic              drain_exit;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [WORD_W-1:0] fifo_head;

  // 17-bit compare so WORDS=65535 cannot wrap the counter.
  assign last_word  = (({1'b0, word_cnt} + 17'd1) == 17'(WORDS));
  assign hs         = bus.rasin_valid && rdy;
  assign lo_hs      = (state == LO) && hs;
  assign push       = (state == HI) && hs;
  assign drain_exit = (state == DRAIN) && fifo_empty;

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (ap_start) state_nx = LO;
      end
      LO: begin
        rdy = 1'b1;
        if (bus.rasin_valid) state_nx = HI;
      end
      HI: begin
        // Registered occupancy only: no combinational path from out_ready.
        rdy = !fifo_full;
        if (bus.rasin_valid && !fifo_full) state_nx = last_word ? DRAIN : LO;
      end
      DRAIN: begin
        if (fifo_empty) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // done is registered on the DRAIN->IDLE edge, so it is high in the same
  // cycle busy first reads low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      word_cnt <= '0;
      done     <= 1'b0;
    end else begin
      if (lo_hs) hold <= bus.rasin_data;
      if (drain_exit)  word_cnt <= '0;
      else if (push)   word_cnt <= word_cnt + 1'b1;
      done <= drain_exit;
    end
  end

  ras_fifo2 #(.W(WORD_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({bus.rasin_data, hold}),
    .pop       (bus.out_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.rasin_ready = rdy;
  assign bus.out_valid   = (fifo_count != 2'd0);
  assign bus.out_data    = fifo_head;
  assign busy            = (state != IDLE);

`ifdef RAS_RX32_FRAMECNT_EN
  logic [CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_cnt_q <= '0;
    else if (drain_exit) frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
